// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state FETCH/EXEC/HALT sequencer that owns the PC,
// the captured instruction word and the retired-instruction counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic        instr_valid,
    output logic        misalign,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    always_comb begin
        next_pc = pc_src ? pc + imm_ext : pc + 32'd4;
    end

    // NOTE: every state register is assigned with <= so that all updates in this
    // block see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            instret <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        // A misaligned target is still committed so the faulting address is visible.
                        pc      <= next_pc;
                        instr   <= NOP_INSTR;
                        instret <= instret + 32'd1;
                        state   <= (next_pc[1:0] == 2'b00) ? FETCH : HALT;
                    end
                end
                HALT: begin
                end
                default: state <= HALT;
            endcase
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign op          = instr[6:0];
    assign instr_valid = (state == EXEC);
    assign misalign    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the fetch/retire rules.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, pc_src, stall, imem_ack;
    logic [31:0] imm_ext, imem_rdata;
    logic        imem_req, instr_valid, misalign;
    logic [31:0] imem_addr, pc, instr, instret;
    logic [6:0]  op;

    int checks = 0;
    int errors = 0;

    // Reference model: what the unit is doing, where it is, what it holds, how many retired.
    typedef enum {M_FETCH, M_EXEC, M_HALT} mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_instr, m_ret;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .imm_ext(imm_ext), .stall(stall),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
        .imem_addr(imem_addr), .pc(pc), .instr(instr), .op(op),
        .instr_valid(instr_valid), .misalign(misalign), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] target;
        if (rst) begin
            m_mode = M_FETCH; m_pc = RESET_PC; m_instr = NOP_INSTR; m_ret = 0;
        end else if (m_mode == M_FETCH) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_mode  = M_EXEC;
            end
        end else if (m_mode == M_EXEC && !stall) begin
            target  = pc_src ? m_pc + imm_ext : m_pc + 4;
            m_pc    = target;
            m_ret   = m_ret + 1;
            m_instr = NOP_INSTR;
            m_mode  = (target % 4 == 0) ? M_FETCH : M_HALT;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("imem_req", {31'd0, imem_req}, {31'd0, m_mode == M_FETCH});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_mode == M_EXEC});
        check("misalign", {31'd0, misalign}, {31'd0, m_mode == M_HALT});
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, m_pc);
        check("instr", instr, m_instr);
        check("op", {25'd0, op}, {25'd0, m_instr[6:0]});
        check("instret", instret, m_ret);
    endtask

    task automatic drive(input logic r, input logic ack, input logic [31:0] data,
                         input logic st, input logic ps, input logic [31:0] imm);
        rst = r; imem_ack = ack; imem_rdata = data; stall = st; pc_src = ps; imm_ext = imm;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0040);
        step();
        check("reset_req", {31'd0, imem_req}, 32'd1);
        check("reset_addr", imem_addr, RESET_PC);
        check("reset_valid", {31'd0, instr_valid}, 32'd0);
        check("reset_misalign", {31'd0, misalign}, 32'd0);
        check("reset_instr", instr, NOP_INSTR);
    endtask

    // Fetch one word with zero-wait memory, then retire it with the given branch.
    task automatic fetch_and_branch(input logic ps, input logic [31:0] imm);
        drive(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0, ps, imm);
        step();
    endtask

    initial begin
        logic [31:0] exp_pc [6];
        logic [31:0] saved_ret;
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8, 32'h8};

        // Zero-wait streaming: one instruction per two cycles.
        do_reset();
        drive(1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            check("stream_pc", pc, exp_pc[i]);
            check("stream_valid", {31'd0, instr_valid}, {31'd0, i[0]});
            step();
        end
        check("stream_instret", instret, 32'd3);

        // Backward and forward branches from 0x10.
        do_reset();
        fetch_and_branch(1'b1, 32'h0000_0010);
        fetch_and_branch(1'b1, 32'hFFFF_FFF8);
        check("branch_back", imem_addr, 32'h0000_0008);
        fetch_and_branch(1'b1, 32'h0000_0008);
        fetch_and_branch(1'b1, 32'h0000_0100);
        check("branch_fwd", imem_addr, 32'h0000_0110);

        // Slow memory: four wait cycles with changing data.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'hA000_0000 + i, 1'b0, 1'b1, 32'h4);
            step();
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h0000_0110);
        end
        drive(1'b0, 1'b1, 32'h1234_5677, 1'b0, 1'b0, 32'h0);
        step();
        check("wait_instr", instr, 32'h1234_5677);

        // Stall in EXEC with ack pulses and pc_src toggling.
        saved_ret = instret;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i[0], 32'hFFFF_FFFF, 1'b1, i[0], 32'h0000_0800);
            step();
            check("stall_instr", instr, 32'h1234_5677);
            check("stall_ret", instret, saved_ret);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
        step();
        check("stall_release", pc, 32'h0000_0150);

        // Misaligned branch target halts until reset.
        do_reset();
        fetch_and_branch(1'b1, 32'h0000_0020);
        fetch_and_branch(1'b1, 32'h0000_0002);
        check("halt_pc", pc, 32'h0000_0022);
        check("halt_ret", instret, 32'd2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, $urandom, $urandom_range(0, 1), 1'b1, 32'h4);
            step();
        end
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_misalign", {31'd0, misalign}, 32'd1);
        do_reset();
        check("halt_cleared_pc", pc, RESET_PC);

        // PC wraps past the top of the address space.
        fetch_and_branch(1'b1, 32'hFFFF_FFFC);
        check("top_pc", pc, 32'hFFFF_FFFC);
        fetch_and_branch(1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] imm;
            if ($urandom_range(0, 9) == 0)
                imm = $urandom;
            else
                imm = {{20{1'b0}}, 12'($urandom_range(0, 1023))} << 2;
            if ($urandom_range(0, 3) == 0) imm = -imm;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1), imm);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
